// File: rtl/tdm_pkg.sv
// Shared constants and state type for the 4-channel TDM receive path.
package tdm_pkg;

  localparam int NCH    = 4;
  localparam int SLOT_W = 2;

  typedef enum logic {
    HUNT,
    LOCKED
  } state_t;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot position and consecutive-missing-sync counter for the TDM demux.
module tdm_slot_ctr
  import tdm_pkg::*;
#(
  parameter int MISS_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv,
  input  logic              sync,
  input  logic              drop,
  input  logic              miss_clr,
  input  logic              miss_inc,
  output logic [SLOT_W-1:0] slot,
  output logic [MISS_W-1:0] miss_cnt
);

  // A sync word forces the current word to slot 0, so the next one is slot 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (drop) begin
      slot <= '0;
    end else if (adv) begin
      slot <= (sync ? '0 : slot) + SLOT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_cnt <= '0;
    end else if (drop || miss_clr) begin
      miss_cnt <= '0;
    end else if (miss_inc) begin
      miss_cnt <= miss_cnt + MISS_W'(1);
    end
  end

endmodule

// File: rtl/tdm_demux_4ch.sv
// 1:4 TDM demultiplexer: frame lock FSM, per-channel holding registers and flags.
module tdm_demux_4ch
  import tdm_pkg::*;
#(
  parameter int W        = 2,
  parameter int MISS_MAX = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   din,
  input  logic           din_valid,
  input  logic           frame_sync,
  input  logic           err_clr,
  output logic [W-1:0]   y0,
  output logic [W-1:0]   y1,
  output logic [W-1:0]   y2,
  output logic [W-1:0]   y3,
  output logic [NCH-1:0] ch_valid,
  output logic           frame_done,
  output logic           locked,
  output logic           sync_err
);

  localparam int MISS_W = (MISS_MAX > 1) ? $clog2(MISS_MAX) : 1;

  state_t              state_q, state_d;
  logic [SLOT_W-1:0]   slot;
  logic [MISS_W-1:0]   miss_cnt;
  logic [SLOT_W-1:0]   tgt;
  logic                accept, drop, miss_clr, miss_inc, set_err;
  logic [W-1:0]        y_q [NCH];

  tdm_slot_ctr #(.MISS_W(MISS_W)) u_slot_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .adv      (accept),
    .sync     (frame_sync),
    .drop     (drop),
    .miss_clr (miss_clr),
    .miss_inc (miss_inc),
    .slot     (slot),
    .miss_cnt (miss_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= HUNT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    drop     = 1'b0;
    miss_clr = 1'b0;
    miss_inc = 1'b0;
    set_err  = 1'b0;
    tgt      = '0;
    if (din_valid) begin
      case (state_q)
        HUNT: begin
          if (frame_sync) begin
            accept   = 1'b1;
            miss_clr = 1'b1;
            state_d  = LOCKED;
          end
        end
        LOCKED: begin
          // Lock is dropped on the slot-0 word that completes MISS_MAX sync-less frames.
          if (slot == '0 && !frame_sync && miss_cnt == MISS_W'(MISS_MAX - 1)) begin
            drop    = 1'b1;
            state_d = HUNT;
          end else begin
            accept   = 1'b1;
            tgt      = frame_sync ? '0 : slot;
            set_err  = frame_sync && (slot != '0);
            miss_clr = (slot == '0) && frame_sync;
            miss_inc = (slot == '0) && !frame_sync;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) y_q[i] <= '0;
      ch_valid   <= '0;
      frame_done <= 1'b0;
    end else begin
      if (accept) y_q[tgt] <= din;
      ch_valid   <= accept ? (NCH'(1) << tgt) : '0;
      frame_done <= accept && (tgt == SLOT_W'(NCH - 1));
    end
  end

  // A new misalignment outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       sync_err <= 1'b0;
    else if (set_err) sync_err <= 1'b1;
    else if (err_clr) sync_err <= 1'b0;
  end

  assign locked = (state_q == LOCKED);
  assign y0 = y_q[0];
  assign y1 = y_q[1];
  assign y2 = y_q[2];
  assign y3 = y_q[3];

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Self-checking bench for tdm_demux_4ch: directed vector table, async reset cases, random vs model.
module tb_tdm_demux_4ch;

  localparam int W        = 2;
  localparam int MISS_MAX = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         frame_sync = 1'b0;
  logic         err_clr = 1'b0;
  logic [W-1:0] y0, y1, y2, y3;
  logic [3:0]   ch_valid;
  logic         frame_done, locked, sync_err;

  int checks = 0;
  int errors = 0;

  tdm_demux_4ch #(.W(W), .MISS_MAX(MISS_MAX)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .err_clr    (err_clr),
    .y0         (y0),
    .y1         (y1),
    .y2         (y2),
    .y3         (y3),
    .ch_valid   (ch_valid),
    .frame_done (frame_done),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         dv;
    logic         fs;
    logic [W-1:0] din;
    logic         clr;
    logic [3:0]   cv;
    logic [W-1:0] ey0, ey1, ey2, ey3;
    logic         lk;
    logic         se;
  } vec_t;

  vec_t vecs[$];

  // Reference model: frame-level view of the receive rules.
  bit           m_lk;
  int           m_slot, m_miss;
  bit           m_se;
  logic [W-1:0] m_y [4];
  logic [3:0]   m_cv;

  function automatic vec_t make_vec(logic dv, logic fs, logic [W-1:0] d, logic clr, logic [3:0] cv,
                                    logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] c, logic [W-1:0] e,
                                    logic lk, logic se);
    vec_t v;
    v.dv = dv; v.fs = fs; v.din = d; v.clr = clr; v.cv = cv;
    v.ey0 = a; v.ey1 = b; v.ey2 = c; v.ey3 = e; v.lk = lk; v.se = se;
    return v;
  endfunction

  task automatic applyStimulus(input logic dv, input logic fs, input logic [W-1:0] d, input logic clr);
    din_valid  = dv;
    frame_sync = fs;
    din        = d;
    err_clr    = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] cv, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [W-1:0] c, input logic [W-1:0] e,
                             input logic lk, input logic se);
    logic [3+1+1+1+4*W-1:0] act, exp_v;
    act   = {ch_valid, frame_done, locked, sync_err, y0, y1, y2, y3};
    exp_v = {cv, cv[3], lk, se, a, b, c, e};
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s: got cv=%b fd=%b lk=%b se=%b y=%0d,%0d,%0d,%0d expected cv=%b fd=%b lk=%b se=%b y=%0d,%0d,%0d,%0d",
               name, ch_valid, frame_done, locked, sync_err, y0, y1, y2, y3,
               cv, cv[3], lk, se, a, b, c, e);
    end
  endtask

  task automatic modelReset();
    m_lk = 0; m_slot = 0; m_miss = 0; m_se = 0; m_cv = '0;
    for (int i = 0; i < 4; i++) m_y[i] = '0;
  endtask

  task automatic modelStep(input logic dv, input logic fs, input logic [W-1:0] d, input logic clr);
    bit new_err;
    int t;
    new_err = 0;
    m_cv = '0;
    if (dv) begin
      if (!m_lk) begin
        if (fs) begin
          m_y[0] = d; m_cv = 4'b0001; m_slot = 1; m_miss = 0; m_lk = 1;
        end
      end else if (m_slot == 0 && !fs && m_miss == MISS_MAX - 1) begin
        m_lk = 0; m_slot = 0; m_miss = 0;
      end else begin
        t = fs ? 0 : m_slot;
        if (fs && m_slot != 0) new_err = 1;
        if (m_slot == 0) m_miss = fs ? 0 : m_miss + 1;
        m_y[t] = d;
        m_cv = 4'(1 << t);
        m_slot = (t + 1) % 4;
      end
    end
    if (new_err) m_se = 1;
    else if (clr) m_se = 0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int phase;
    logic dv, fs, clr;
    logic [W-1:0] d;

    // Reset state, asserted and then released with the link idle.
    rst_n = 1'b0;
    #2;
    checkOutput("reset_async", 4'b0000, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    checkOutput("reset_held", 4'b0000, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("reset_release_idle", 4'b0000, 0, 0, 0, 0, 0, 0);

    // dv fs din clr | ch_valid y0 y1 y2 y3 locked sync_err
    vecs.push_back(make_vec(1, 0, 1, 0, 4'b0000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(make_vec(1, 0, 1, 0, 4'b0000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(make_vec(1, 0, 1, 0, 4'b0000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(make_vec(1, 1, 0, 0, 4'b0001, 0, 0, 0, 0, 1, 0));
    vecs.push_back(make_vec(1, 0, 1, 0, 4'b0010, 0, 1, 0, 0, 1, 0));
    vecs.push_back(make_vec(1, 0, 2, 0, 4'b0100, 0, 1, 2, 0, 1, 0));
    vecs.push_back(make_vec(1, 0, 3, 0, 4'b1000, 0, 1, 2, 3, 1, 0));
    vecs.push_back(make_vec(1, 1, 0, 0, 4'b0001, 0, 1, 2, 3, 1, 0));
    vecs.push_back(make_vec(1, 0, 1, 0, 4'b0010, 0, 1, 2, 3, 1, 0));
    vecs.push_back(make_vec(1, 1, 3, 0, 4'b0001, 3, 1, 2, 3, 1, 1));
    vecs.push_back(make_vec(1, 0, 2, 0, 4'b0010, 3, 2, 2, 3, 1, 1));
    vecs.push_back(make_vec(0, 0, 1, 0, 4'b0000, 3, 2, 2, 3, 1, 1));
    vecs.push_back(make_vec(1, 0, 1, 1, 4'b0100, 3, 2, 1, 3, 1, 0));
    vecs.push_back(make_vec(1, 1, 2, 1, 4'b0001, 2, 2, 1, 3, 1, 1));
    vecs.push_back(make_vec(1, 0, 0, 0, 4'b0010, 2, 0, 1, 3, 1, 1));
    vecs.push_back(make_vec(1, 0, 1, 0, 4'b0100, 2, 0, 1, 3, 1, 1));
    vecs.push_back(make_vec(1, 0, 3, 0, 4'b1000, 2, 0, 1, 3, 1, 1));
    vecs.push_back(make_vec(1, 0, 2, 0, 4'b0001, 2, 0, 1, 3, 1, 1));
    vecs.push_back(make_vec(1, 0, 1, 0, 4'b0010, 2, 1, 1, 3, 1, 1));
    vecs.push_back(make_vec(1, 0, 0, 0, 4'b0100, 2, 1, 0, 3, 1, 1));
    vecs.push_back(make_vec(1, 0, 3, 0, 4'b1000, 2, 1, 0, 3, 1, 1));
    vecs.push_back(make_vec(1, 0, 1, 0, 4'b0000, 2, 1, 0, 3, 0, 1));
    vecs.push_back(make_vec(1, 0, 2, 0, 4'b0000, 2, 1, 0, 3, 0, 1));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].dv, vecs[i].fs, vecs[i].din, vecs[i].clr);
      checkOutput($sformatf("vec%0d", i), vecs[i].cv, vecs[i].ey0, vecs[i].ey1,
                  vecs[i].ey2, vecs[i].ey3, vecs[i].lk, vecs[i].se);
    end

    // Mid-frame reset: lock, advance to slot 2, then drop rst_n between edges.
    applyStimulus(1, 1, 1, 0);
    applyStimulus(1, 0, 2, 0);
    checkOutput("pre_midreset", 4'b0010, 1, 2, 0, 3, 1, 1);
    rst_n = 1'b0;
    #2;
    checkOutput("midreset_async", 4'b0000, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(1, 0, 3, 0);
    checkOutput("post_reset_discard0", 4'b0000, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 0);
    checkOutput("post_reset_discard1", 4'b0000, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 2, 0);
    checkOutput("post_reset_relock", 4'b0001, 2, 0, 0, 0, 1, 0);

    // Random traffic against the reference model, starting from a fresh reset.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0);
    modelReset();
    phase = 0;
    for (int n = 0; n < 2000; n++) begin
      dv  = ($urandom_range(0, 3) != 0);
      fs  = ((phase == 0) && ($urandom_range(0, 7) != 0)) || ($urandom_range(0, 15) == 0);
      d   = W'($urandom);
      clr = ($urandom_range(0, 9) == 0);
      if (dv) phase = (phase + 1) % 4;
      applyStimulus(dv, fs, d, clr);
      modelStep(dv, fs, d, clr);
      checkOutput($sformatf("rand%0d", n), m_cv, m_y[0], m_y[1], m_y[2], m_y[3], m_lk, m_se);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
